// File: rtl/wolverine_dispatch_responder.sv
// Dispatch responder: accepts host instructions, launches a kernel and tracks it to
// completion, and serves host/kernel access to the 64-bit AEG register file.
module wolverine_dispatch_responder #(
    parameter int unsigned AEG_CNT = 16,
    parameter int unsigned NUM_OPS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        disp_inst_valid,
    input  logic [4:0]  disp_inst_data,
    input  logic [17:0] disp_reg_id,
    input  logic        disp_reg_read,
    input  logic        disp_reg_write,
    input  logic [63:0] disp_reg_wr_data,
    output logic [17:0] disp_aeg_cnt,
    output logic [15:0] disp_exception,
    output logic        disp_idle,
    output logic        disp_rtn_valid,
    output logic [63:0] disp_rtn_data,
    output logic        disp_stall,
    output logic        k_start,
    output logic [4:0]  k_opcode,
    input  logic        k_done,
    input  logic [7:0]  k_aeg_rd_idx,
    output logic [63:0] k_aeg_rd_data,
    input  logic        k_aeg_wr_valid,
    input  logic [7:0]  k_aeg_wr_idx,
    input  logic [63:0] k_aeg_wr_data
);

    localparam int unsigned IDX_W = (AEG_CNT > 1) ? $clog2(AEG_CNT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  k_opcode_q, k_opcode_d;
    logic [3:0]  exc_q, exc_d;
    logic        rtn_valid_q, rtn_valid_d;
    logic [63:0] rtn_data_q, rtn_data_d;
    logic [63:0] aeg_q [AEG_CNT];
    logic [63:0] aeg_d [AEG_CNT];

    logic             host_in_range;
    logic             kwr_in_range;
    logic             krd_in_range;
    logic             op_ok;
    logic [IDX_W-1:0] host_idx;
    logic [IDX_W-1:0] kwr_idx;
    logic [IDX_W-1:0] krd_idx;

    assign host_in_range = 32'(disp_reg_id) < AEG_CNT;
    assign kwr_in_range  = 32'(k_aeg_wr_idx) < AEG_CNT;
    assign krd_in_range  = 32'(k_aeg_rd_idx) < AEG_CNT;
    assign op_ok         = 32'(disp_inst_data) < NUM_OPS;
    assign host_idx      = disp_reg_id[IDX_W-1:0];
    assign kwr_idx       = k_aeg_wr_idx[IDX_W-1:0];
    assign krd_idx       = k_aeg_rd_idx[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        k_opcode_d  = k_opcode_q;
        exc_d       = exc_q;
        rtn_valid_d = disp_reg_read;
        rtn_data_d  = '0;
        aeg_d       = aeg_q;

        // Read data comes from the pre-write array so a same-cycle write is not visible.
        if (disp_reg_read && host_in_range) begin
            rtn_data_d = aeg_q[host_idx];
        end
        if ((disp_reg_read || disp_reg_write) && !host_in_range) begin
            exc_d[1] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (disp_inst_valid) begin
                    if (op_ok) begin
                        state_d    = ST_LAUNCH;
                        k_opcode_d = disp_inst_data;
                    end else begin
                        exc_d[0] = 1'b1;
                    end
                end
            end
            ST_LAUNCH: state_d = k_done ? ST_IDLE : ST_BUSY;
            ST_BUSY: begin
                if (k_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE) begin
            if (disp_inst_valid) exc_d[2] = 1'b1;
            if (disp_reg_write)  exc_d[3] = 1'b1;
        end

        // Host write is applied last so it wins any same-index collision.
        if (state_q == ST_BUSY && k_aeg_wr_valid && kwr_in_range) begin
            aeg_d[kwr_idx] = k_aeg_wr_data;
        end
        if (state_q == ST_IDLE && disp_reg_write && host_in_range) begin
            aeg_d[host_idx] = disp_reg_wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_opcode_q  <= '0;
            exc_q       <= '0;
            rtn_valid_q <= 1'b0;
            rtn_data_q  <= '0;
            aeg_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            k_opcode_q  <= k_opcode_d;
            exc_q       <= exc_d;
            rtn_valid_q <= rtn_valid_d;
            rtn_data_q  <= rtn_data_d;
            aeg_q       <= aeg_d;
        end
    end

    assign disp_aeg_cnt   = 18'(AEG_CNT);
    assign disp_exception = {12'b0, exc_q};
    assign disp_idle      = (state_q == ST_IDLE);
    assign disp_stall     = (state_q != ST_IDLE);
    assign disp_rtn_valid = rtn_valid_q;
    assign disp_rtn_data  = rtn_data_q;
    assign k_start        = (state_q == ST_LAUNCH);
    assign k_opcode       = k_opcode_q;
    assign k_aeg_rd_data  = krd_in_range ? aeg_q[krd_idx] : '0;

endmodule

// File: doc/wolverine_dispatch_responder.md
WOLVERINE_DISPATCH_RESPONDER -- requirements
Module: wolverine_dispatch_responder

Interface
REQ-001 SHALL have parameter AEG_CNT, default 16, meaning the number of 64-bit AEG registers (1..256).
REQ-002 SHALL have parameter NUM_OPS, default 4, meaning valid dispatch opcodes are 0..NUM_OPS-1.
REQ-003 SHALL have port: clock, input, 1, clock; all logic on its rising edge.
REQ-004 SHALL have port: reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port: disp_inst_valid, input, 1, host dispatch instruction strobe.
REQ-006 SHALL have port: disp_inst_data, input, 5, instruction opcode.
REQ-007 SHALL have port: disp_reg_id, input, 18, AEG index for register access.
REQ-008 SHALL have port: disp_reg_read, input, 1, AEG read strobe.
REQ-009 SHALL have port: disp_reg_write, input, 1, AEG write strobe.
REQ-010 SHALL have port: disp_reg_wr_data, input, 64, AEG write data.
REQ-011 SHALL have port: disp_aeg_cnt, output, 18, constant AEG_CNT.
REQ-012 SHALL have port: disp_exception, output, 16, sticky exception flags.
REQ-013 SHALL have port: disp_idle, output, 1, no instruction executing.
REQ-014 SHALL have port: disp_rtn_valid, output, 1, read return strobe.
REQ-015 SHALL have port: disp_rtn_data, output, 64, read return data.
REQ-016 SHALL have port: disp_stall, output, 1, responder cannot accept an instruction.
REQ-017 SHALL have ports: k_start, output, 1, one-cycle kernel launch pulse; k_opcode, output, 5, latched opcode; k_done, input, 1, kernel completion pulse.
REQ-018 SHALL have ports: k_aeg_rd_idx, input, 8; k_aeg_rd_data, output, 64, combinational AEG read (0 if idx >= AEG_CNT).
REQ-019 SHALL have ports: k_aeg_wr_valid, input, 1; k_aeg_wr_idx, input, 8; k_aeg_wr_data, input, 64, kernel result write.

Function
REQ-020 SHALL implement FSM states IDLE, LAUNCH, BUSY.
- IDLE: disp_inst_valid with opcode < NUM_OPS -> LAUNCH; latch k_opcode.
- LAUNCH: k_start=1 for exactly one cycle -> BUSY.
- BUSY: k_done=1 -> IDLE.
REQ-021 SHALL treat k_done sampled in the LAUNCH cycle as completion and go directly to IDLE.
REQ-022 SHALL drive disp_stall=1 and disp_idle=0 whenever state != IDLE; first asserted the cycle after instruction acceptance; deasserted the cycle after k_done.
REQ-023 SHALL, for disp_inst_valid in IDLE with opcode >= NUM_OPS, stay in IDLE and set disp_exception[0].
REQ-024 SHALL, for disp_inst_valid while state != IDLE, drop the instruction and set disp_exception[2].
REQ-025 SHALL, on disp_reg_read at cycle N, assert disp_rtn_valid for exactly one cycle at N+1, with disp_rtn_data = AEG[disp_reg_id] as of cycle N.
- Reads are allowed in any state.
- disp_rtn_data SHALL be 0 whenever disp_rtn_valid=0.
REQ-026 SHALL, on disp_reg_read or disp_reg_write with disp_reg_id >= AEG_CNT, set disp_exception[1]; the read still returns data 0 at N+1, and the write is discarded.
REQ-027 SHALL apply a disp_reg_write only in IDLE; in LAUNCH/BUSY it is discarded and disp_exception[3] is set.
REQ-028 SHALL apply k_aeg_wr_valid writes only in BUSY; writes with k_aeg_wr_idx >= AEG_CNT are discarded silently.
REQ-029 SHALL, when a host write and a kernel write target the same index in the same cycle, let the host write win (reachable only via a BUSY->IDLE edge case; define it regardless).
REQ-030 SHALL, on a simultaneous read and write to the same index, return the pre-write value.
REQ-031 SHALL keep disp_exception bits sticky, cleared only by reset; bits [15:4] are constant 0.

Reset
REQ-032 SHALL, with reset=1 at a clock edge, enter IDLE and clear all AEG registers to 0.
REQ-033 SHALL drive these reset values: disp_exception=0, disp_rtn_valid=0, disp_rtn_data=0, disp_stall=0, disp_idle=1, k_start=0, k_opcode=0.
REQ-034 SHALL, on reset mid-operation (LAUNCH/BUSY), abort with no k_start pulse and ignore k_done in the reset cycle.

Verification
REQ-035 SHALL pass this scenario: write AEG[3]=0xDEAD_BEEF in IDLE, then read id 3 at cycle N -> disp_rtn_valid=1, data 0xDEADBEEF at N+1 only.
REQ-036 SHALL pass this scenario: inst opcode 2 at N -> k_start=1 and k_opcode=2 at N+1, stall=1 and idle=0 from N+1; k_done at N+5 -> stall=0, idle=1 at N+6.
REQ-037 SHALL pass this scenario: inst opcode 7 (NUM_OPS=4) -> no k_start, disp_exception=0x0001; then read id 20 -> rtn data 0, disp_exception=0x0003.
REQ-038 SHALL pass this scenario: in BUSY, issue an instruction and a host write to AEG[1]=5 -> disp_exception=0x000C, AEG[1] unchanged; kernel writes AEG[1]=9 -> a later read returns 9.
REQ-039 SHALL pass this scenario: k_done in the LAUNCH cycle -> IDLE the next cycle, one k_start pulse total.
REQ-040 SHALL pass this scenario: reset asserted in BUSY -> next cycle idle=1, stall=0, exception=0, AEG[3] reads 0.
